// File: rtl/mux_32.sv
// 32:1 multiplexer of N-bit buses: combinational out plus a registered copy out_q.
// Define MUX32_PARITY_EN to add out_par, a registered even parity of out.
module mux_32 #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in00,
    input  logic [N-1:0] in01,
    input  logic [N-1:0] in02,
    input  logic [N-1:0] in03,
    input  logic [N-1:0] in04,
    input  logic [N-1:0] in05,
    input  logic [N-1:0] in06,
    input  logic [N-1:0] in07,
    input  logic [N-1:0] in08,
    input  logic [N-1:0] in09,
    input  logic [N-1:0] in10,
    input  logic [N-1:0] in11,
    input  logic [N-1:0] in12,
    input  logic [N-1:0] in13,
    input  logic [N-1:0] in14,
    input  logic [N-1:0] in15,
    input  logic [N-1:0] in16,
    input  logic [N-1:0] in17,
    input  logic [N-1:0] in18,
    input  logic [N-1:0] in19,
    input  logic [N-1:0] in20,
    input  logic [N-1:0] in21,
    input  logic [N-1:0] in22,
    input  logic [N-1:0] in23,
    input  logic [N-1:0] in24,
    input  logic [N-1:0] in25,
    input  logic [N-1:0] in26,
    input  logic [N-1:0] in27,
    input  logic [N-1:0] in28,
    input  logic [N-1:0] in29,
    input  logic [N-1:0] in30,
    input  logic [N-1:0] in31,
    input  logic [4:0]   select,
    output logic [N-1:0] out,
    output logic [N-1:0] out_q
`ifdef MUX32_PARITY_EN
    ,
    output logic         out_par
`endif
);

    logic [N-1:0] w_l0 [32];
    logic [N-1:0] w_l1 [16];
    logic [N-1:0] w_l2 [8];
    logic [N-1:0] w_l3 [4];
    logic [N-1:0] w_l4 [2];
    logic [N-1:0] r_out_q;

    assign w_l0[0]  = in00;  assign w_l0[1]  = in01;  assign w_l0[2]  = in02;  assign w_l0[3]  = in03;
    assign w_l0[4]  = in04;  assign w_l0[5]  = in05;  assign w_l0[6]  = in06;  assign w_l0[7]  = in07;
    assign w_l0[8]  = in08;  assign w_l0[9]  = in09;  assign w_l0[10] = in10;  assign w_l0[11] = in11;
    assign w_l0[12] = in12;  assign w_l0[13] = in13;  assign w_l0[14] = in14;  assign w_l0[15] = in15;
    assign w_l0[16] = in16;  assign w_l0[17] = in17;  assign w_l0[18] = in18;  assign w_l0[19] = in19;
    assign w_l0[20] = in20;  assign w_l0[21] = in21;  assign w_l0[22] = in22;  assign w_l0[23] = in23;
    assign w_l0[24] = in24;  assign w_l0[25] = in25;  assign w_l0[26] = in26;  assign w_l0[27] = in27;
    assign w_l0[28] = in28;  assign w_l0[29] = in29;  assign w_l0[30] = in30;  assign w_l0[31] = in31;

    // Tree of 2:1 selections: select[0] picks between leaf pairs, select[4] at the root.
    for (genvar g = 0; g < 16; g++) begin : g_l1
        assign w_l1[g] = select[0] ? w_l0[2*g+1] : w_l0[2*g];
    end
    for (genvar g = 0; g < 8; g++) begin : g_l2
        assign w_l2[g] = select[1] ? w_l1[2*g+1] : w_l1[2*g];
    end
    for (genvar g = 0; g < 4; g++) begin : g_l3
        assign w_l3[g] = select[2] ? w_l2[2*g+1] : w_l2[2*g];
    end
    for (genvar g = 0; g < 2; g++) begin : g_l4
        assign w_l4[g] = select[3] ? w_l3[2*g+1] : w_l3[2*g];
    end
    assign out = select[4] ? w_l4[1] : w_l4[0];

    // NOTE: non-blocking assignment so out_q captures out as it was before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_out_q <= '0;
        else        r_out_q <= out;
    end
    assign out_q = r_out_q;

`ifdef MUX32_PARITY_EN
    logic r_out_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_out_par <= 1'b0;
        else        r_out_par <= ^out;
    end
    assign out_par = r_out_par;
`endif

endmodule

// File: tb/tb_mux_32.sv
// Self-checking bench for mux_32: N=5 and N=1 instances, table sweep plus
// hand-written sequences for data changes, register lag, async reset and parity.
module tb_mux_32;

    typedef struct {
        logic [4:0] sel;
        logic [4:0] exp5;
        logic       exp1;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] select;
    logic [4:0] a5 [32];
    logic       a1 [32];
    logic [4:0] out5, out5_q;
    logic       out1, out1_q;
`ifdef MUX32_PARITY_EN
    logic       par5, par1;
`endif

    int n_cmp;
    int n_fail;

    vec_t vecs [32];

    mux_32 #(.N(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n),
        .in00(a5[0]),  .in01(a5[1]),  .in02(a5[2]),  .in03(a5[3]),
        .in04(a5[4]),  .in05(a5[5]),  .in06(a5[6]),  .in07(a5[7]),
        .in08(a5[8]),  .in09(a5[9]),  .in10(a5[10]), .in11(a5[11]),
        .in12(a5[12]), .in13(a5[13]), .in14(a5[14]), .in15(a5[15]),
        .in16(a5[16]), .in17(a5[17]), .in18(a5[18]), .in19(a5[19]),
        .in20(a5[20]), .in21(a5[21]), .in22(a5[22]), .in23(a5[23]),
        .in24(a5[24]), .in25(a5[25]), .in26(a5[26]), .in27(a5[27]),
        .in28(a5[28]), .in29(a5[29]), .in30(a5[30]), .in31(a5[31]),
        .select(select), .out(out5), .out_q(out5_q)
`ifdef MUX32_PARITY_EN
        , .out_par(par5)
`endif
    );

    mux_32 #(.N(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in00(a1[0]),  .in01(a1[1]),  .in02(a1[2]),  .in03(a1[3]),
        .in04(a1[4]),  .in05(a1[5]),  .in06(a1[6]),  .in07(a1[7]),
        .in08(a1[8]),  .in09(a1[9]),  .in10(a1[10]), .in11(a1[11]),
        .in12(a1[12]), .in13(a1[13]), .in14(a1[14]), .in15(a1[15]),
        .in16(a1[16]), .in17(a1[17]), .in18(a1[18]), .in19(a1[19]),
        .in20(a1[20]), .in21(a1[21]), .in22(a1[22]), .in23(a1[23]),
        .in24(a1[24]), .in25(a1[25]), .in26(a1[26]), .in27(a1[27]),
        .in28(a1[28]), .in29(a1[29]), .in30(a1[30]), .in31(a1[31]),
        .select(select), .out(out1), .out_q(out1_q)
`ifdef MUX32_PARITY_EN
        , .out_par(par1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) begin
            vecs[i].sel  = 5'(i);
            vecs[i].exp5 = 5'(i);
            vecs[i].exp1 = (i == 0);
            a5[i] = 5'(i);
            a1[i] = (i == 0);
        end

        // Reset state
        rst_n  = 1'b0;
        select = 5'd0;
        #3;
        check("reset_out_q5", 32'(out5_q), 32'd0);
        check("reset_out_q1", 32'(out1_q), 32'd0);
        check("reset_out5_live", 32'(out5), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational sweep from the vector table
        for (int i = 0; i < 32; i++) begin
            select = vecs[i].sel;
            #1;
            check($sformatf("sweep_out5_sel%0d", i), 32'(out5), 32'(vecs[i].exp5));
            check($sformatf("sweep_out1_sel%0d", i), 32'(out1), 32'(vecs[i].exp1));
        end

        // Selected vs unselected input changes
        select = 5'd7;
        #1;
        a5[7] = 5'b10101;
        #1;
        check("sel_input_change", 32'(out5), 32'b10101);
        a5[8] = 5'b11111;
        #1;
        check("unsel_input_change", 32'(out5), 32'b10101);
        a5[7] = 5'd7;
        a5[8] = 5'd8;
        #1;
        check("sel_input_restore", 32'(out5), 32'd7);

        // Registered output lags out by one cycle
        @(negedge clk);
        select = 5'd0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check($sformatf("lag_out_q5_%0d", i), 32'(out5_q), 32'(i));
            if (i == 0 || i == 31)
                check($sformatf("lag_out_q1_%0d", i), 32'(out1_q), 32'(i == 0));
            select = 5'(i + 1);
        end

        // Asynchronous reset mid-cycle
        select = 5'd31;
        @(posedge clk);
        #1;
        check("pre_reset_out_q", 32'(out5_q), 32'd31);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_q", 32'(out5_q), 32'd0);
        check("async_reset_out", 32'(out5), 32'd31);
        @(negedge clk);
        check("reset_held_out_q", 32'(out5_q), 32'd0);
        rst_n = 1'b1;
        #1;
        check("release_before_edge", 32'(out5_q), 32'd0);
        @(posedge clk);
        #1;
        check("release_first_edge", 32'(out5_q), 32'd31);

`ifdef MUX32_PARITY_EN
        @(negedge clk);
        select = 5'd7;
        @(negedge clk);
        check("parity_sel7", 32'(par5), 32'd1);
        select = 5'd3;
        @(negedge clk);
        check("parity_sel3", 32'(par5), 32'd0);
        select = 5'd7;
        @(negedge clk);
        check("parity_sel7_again", 32'(par5), 32'd1);
        rst_n = 1'b0;
        #1;
        check("parity_reset", 32'(par5), 32'd0);
        rst_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
